// File: rtl/fetch_decode_pipe.sv
// Front end of the 5-stage MIPS core: PC register, IF/ID and ID/EX pipeline
// registers. Applies the hazard unit's stall/flush requests and branch/jump
// redirects with fixed priority. Debug counters track stall and flush events.
module fetch_decode_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 12,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushE,
  input  logic              pcsrcD,
  input  logic              jumpD,
  input  logic [31:0]       pcbranchD,
  input  logic [31:0]       pcjumpD,
  input  logic [31:0]       instrF,
  input  logic [CTRL_W-1:0] ctrlD,
  output logic [31:0]       pcF,
  output logic [31:0]       instrD,
  output logic [31:0]       pcplus4D,
  output logic              validD,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [4:0]        rsE,
  output logic [4:0]        rtE,
  output logic [4:0]        rdE,
  output logic [31:0]       pcplus4E,
  output logic              validE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              protocol_err
);

  // Fetch stage
  logic [31:0]       pc_q, pc_d;
  // IF/ID register
  logic [31:0]       instr_d_q, instr_d_d;
  logic [31:0]       pcp4_d_q, pcp4_d_d;
  logic              valid_d_q, valid_d_d;
  // ID/EX register
  logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
  logic [4:0]        rs_e_q, rs_e_d;
  logic [4:0]        rt_e_q, rt_e_d;
  logic [4:0]        rd_e_q, rd_e_d;
  logic [31:0]       pcp4_e_q, pcp4_e_d;
  logic              valid_e_q, valid_e_d;
  // Debug state
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              perr_q, perr_d;

  logic              redirect;
  logic [31:0]       pc_plus4;

  // A branch/jump in D is only acted on once D is allowed to advance; while
  // D is stalled its operands may still be in flight.
  assign redirect = (jumpD | pcsrcD) & ~stallD;
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state selection for all pipeline and debug registers.
  always_comb begin
    // NOTE: every target gets a default (hold or natural next value) before
    // any branch, so no path leaves a signal unassigned and no latch appears.
    pc_d        = pc_plus4;
    instr_d_d   = instr_d_q;
    pcp4_d_d    = pcp4_d_q;
    valid_d_d   = valid_d_q;
    ctrl_e_d    = ctrlD;
    rs_e_d      = instr_d_q[25:21];
    rt_e_d      = instr_d_q[20:16];
    rd_e_d      = instr_d_q[15:11];
    pcp4_e_d    = pcp4_d_q;
    valid_e_d   = valid_d_q;
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stallD};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, redirect};
    perr_d      = perr_q | (stallF ^ stallD);

    // PC: hold beats jump, jump beats branch, branch beats sequential.
    if (stallF) begin
      pc_d = pc_q;
    end else if (jumpD && !stallD) begin
      pc_d = pcjumpD;
    end else if (pcsrcD && !stallD) begin
      pc_d = pcbranchD;
    end

    // IF/ID: hold on stall, squash the wrong-path fetch on redirect (no delay
    // slot), otherwise capture the fetched word.
    if (!stallD) begin
      if (redirect) begin
        instr_d_d = 32'h0;
        pcp4_d_d  = 32'h0;
        valid_d_d = 1'b0;
      end else begin
        instr_d_d = instrF;
        pcp4_d_d  = pc_plus4;
        valid_d_d = 1'b1;
      end
    end

    // ID/EX: no hold path; a stalled D stage relies on flushE for a bubble.
    if (flushE) begin
      ctrl_e_d  = '0;
      rs_e_d    = 5'd0;
      rt_e_d    = 5'd0;
      rd_e_d    = 5'd0;
      pcp4_e_d  = 32'h0;
      valid_e_d = 1'b0;
    end
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_d_q   <= 32'h0;
      pcp4_d_q    <= 32'h0;
      valid_d_q   <= 1'b0;
      ctrl_e_q    <= '0;
      rs_e_q      <= 5'd0;
      rt_e_q      <= 5'd0;
      rd_e_q      <= 5'd0;
      pcp4_e_q    <= 32'h0;
      valid_e_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_d_q   <= instr_d_d;
      pcp4_d_q    <= pcp4_d_d;
      valid_d_q   <= valid_d_d;
      ctrl_e_q    <= ctrl_e_d;
      rs_e_q      <= rs_e_d;
      rt_e_q      <= rt_e_d;
      rd_e_q      <= rd_e_d;
      pcp4_e_q    <= pcp4_e_d;
      valid_e_q   <= valid_e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      perr_q      <= perr_d;
    end
  end

  assign pcF          = pc_q;
  assign instrD       = instr_d_q;
  assign pcplus4D     = pcp4_d_q;
  assign validD       = valid_d_q;
  assign ctrlE        = ctrl_e_q;
  assign rsE          = rs_e_q;
  assign rtE          = rt_e_q;
  assign rdE          = rd_e_q;
  assign pcplus4E     = pcp4_e_q;
  assign validE       = valid_e_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Bench for fetch_decode_pipe: directed scenarios plus a randomized run
// compared cycle by cycle with a behavioural model of the pipeline front end.
module tb_fetch_decode_pipe;

  localparam int          CTRL_W   = 12;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr_d;
    logic [31:0]       pcp4_d;
    logic              v_d;
    logic [CTRL_W-1:0] ctrl_e;
    logic [4:0]        rs, rt, rd;
    logic [31:0]       pcp4_e;
    logic              v_e;
    logic [CNT_W-1:0]  scnt, fcnt;
    logic              perr;
  } st_t;

  logic              clk = 1'b0;
  logic              reset, stallF, stallD, flushE, pcsrcD, jumpD;
  logic [31:0]       pcbranchD, pcjumpD, instrF;
  logic [CTRL_W-1:0] ctrlD;
  logic [31:0]       pcF, instrD, pcplus4D, pcplus4E;
  logic              validD, validE, protocol_err;
  logic [CTRL_W-1:0] ctrlE;
  logic [4:0]        rsE, rtE, rdE;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  st_t  m;
  st_t  rst_st;

  fetch_decode_pipe #(.RESET_PC(RESET_PC), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .pcsrcD(pcsrcD), .jumpD(jumpD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
    .instrF(instrF), .ctrlD(ctrlD), .pcF(pcF), .instrD(instrD),
    .pcplus4D(pcplus4D), .validD(validD), .ctrlE(ctrlE), .rsE(rsE), .rtE(rtE),
    .rdE(rdE), .pcplus4E(pcplus4E), .validE(validE), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Instruction memory: a fixed scrambled word per PC.
  function automatic logic [31:0] imem(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  assign instrF = imem(pcF);

  function automatic st_t obs();
    return '{pc: pcF, instr_d: instrD, pcp4_d: pcplus4D, v_d: validD,
             ctrl_e: ctrlE, rs: rsE, rt: rtE, rd: rdE, pcp4_e: pcplus4E,
             v_e: validE, scnt: stall_cnt, fcnt: flush_cnt, perr: protocol_err};
  endfunction

  // Behavioural model: what each stage holds after one clock given the
  // currently driven inputs.
  function automatic st_t model_step(input st_t s);
    st_t n;
    bit  taken;
    if (reset) return rst_st;
    n     = s;
    taken = (jumpD || pcsrcD) && !stallD;
    // Execute stage receives whatever decode held, or a bubble.
    if (flushE) begin
      n.ctrl_e = '0; n.rs = 0; n.rt = 0; n.rd = 0; n.pcp4_e = 0; n.v_e = 0;
    end else begin
      n.ctrl_e = ctrlD;
      n.rs = s.instr_d[25:21]; n.rt = s.instr_d[20:16]; n.rd = s.instr_d[15:11];
      n.pcp4_e = s.pcp4_d; n.v_e = s.v_d;
    end
    // Decode stage.
    if (!stallD) begin
      if (taken) begin
        n.instr_d = 0; n.pcp4_d = 0; n.v_d = 0;
      end else begin
        n.instr_d = imem(s.pc); n.pcp4_d = s.pc + 4; n.v_d = 1;
      end
    end
    // Fetch stage.
    if (!stallF) begin
      if (jumpD && !stallD)       n.pc = pcjumpD;
      else if (pcsrcD && !stallD) n.pc = pcbranchD;
      else                        n.pc = s.pc + 4;
    end
    n.scnt = CNT_W'((int'(s.scnt) + (stallD ? 1 : 0)) % (1 << CNT_W));
    n.fcnt = CNT_W'((int'(s.fcnt) + (taken ? 1 : 0)) % (1 << CNT_W));
    n.perr = s.perr || (stallF != stallD);
    return n;
  endfunction

  task automatic idle();
    reset = 0; stallF = 0; stallD = 0; flushE = 0; pcsrcD = 0; jumpD = 0;
    pcbranchD = 0; pcjumpD = 0; ctrlD = 12'h5C3;
  endtask

  // Advance one clock; model follows the same inputs; sample 1 time unit later.
  task automatic tick();
    st_t nx;
    nx = model_step(m);
    @(posedge clk);
    #1;
    m = nx;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    idle();
    stallF = 1; stallD = 0; pcsrcD = 1; jumpD = 1; pcjumpD = 32'h44; flushE = 0;
    reset = 1; tick(); idle();
    n_checks++;
    if (obs() !== rst_st) begin
      n_fail++; $display("FAIL reset_state: got %h, expected %h", obs(), rst_st);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if ({pcF, validD, validE} !== {32'(4 * k), 1'b1, (k >= 2)}) begin
        n_fail++;
        $display("FAIL seq_pc_valid[%0d]: got pc=%h vD=%b vE=%b, expected pc=%h vD=1 vE=%b",
                 k, pcF, validD, validE, 32'(4 * k), (k >= 2));
      end
    end
    n_checks++;
    if (obs() !== m) begin
      n_fail++; $display("FAIL seq_model: got %h, expected %h", obs(), m);
    end
  endtask

  task automatic test_stall();
    do_reset(); tick(); tick();
    stallF = 1; stallD = 1; flushE = 1; tick(); idle();
    n_checks++;
    if ({pcF, instrD, validE, ctrlE, stall_cnt, protocol_err} !==
        {32'h8, imem(32'h4), 1'b0, 12'h000, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_bubble: got pc=%h iD=%h vE=%b cE=%h sc=%0d pe=%b, expected pc=8 iD=%h vE=0 cE=0 sc=1 pe=0",
               pcF, instrD, validE, ctrlE, stall_cnt, protocol_err, imem(32'h4));
    end
    tick();
    n_checks++;
    if (obs() !== m) begin
      n_fail++; $display("FAIL stall_resume: got %h, expected %h", obs(), m);
    end
  endtask

  task automatic test_branch();
    do_reset(); tick(); tick();
    pcsrcD = 1; pcbranchD = 32'h40; tick(); idle();
    n_checks++;
    if ({pcF, instrD, validD, flush_cnt} !== {32'h40, 32'h0, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL branch_redirect: got pc=%h iD=%h vD=%b fc=%0d, expected pc=40 iD=0 vD=0 fc=1",
               pcF, instrD, validD, flush_cnt);
    end
  endtask

  task automatic test_jump_priority();
    pcsrcD = 1; pcbranchD = 32'h40; jumpD = 1; pcjumpD = 32'h80; tick(); idle();
    n_checks++;
    if ({pcF, flush_cnt} !== {32'h80, 4'd2}) begin
      n_fail++;
      $display("FAIL jump_over_branch: got pc=%h fc=%0d, expected pc=80 fc=2", pcF, flush_cnt);
    end
  endtask

  task automatic test_stalled_branch();
    do_reset(); tick(); tick();
    stallF = 1; stallD = 1; pcsrcD = 1; pcbranchD = 32'h40; tick();
    n_checks++;
    if ({pcF, flush_cnt, validD} !== {32'h8, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL stalled_branch_hold: got pc=%h fc=%0d vD=%b, expected pc=8 fc=0 vD=1",
               pcF, flush_cnt, validD);
    end
    stallF = 0; stallD = 0; tick(); idle();
    n_checks++;
    if ({pcF, flush_cnt, validD} !== {32'h40, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL stalled_branch_release: got pc=%h fc=%0d vD=%b, expected pc=40 fc=1 vD=0",
               pcF, flush_cnt, validD);
    end
  endtask

  task automatic test_protocol_and_wrap();
    do_reset(); tick();
    stallF = 1; stallD = 0; tick(); idle();
    n_checks++;
    if (protocol_err !== 1'b1) begin
      n_fail++; $display("FAIL perr_set: got %b, expected 1", protocol_err);
    end
    n_checks++;
    if (pcF !== 32'h4) begin
      n_fail++; $display("FAIL perr_pc_held: got %h, expected 00000004", pcF);
    end
    tick(); tick();
    n_checks++;
    if (protocol_err !== 1'b1) begin
      n_fail++; $display("FAIL perr_sticky: got %b, expected 1", protocol_err);
    end
    stallF = 1; stallD = 1; flushE = 1; reset = 1; tick(); idle();
    n_checks++;
    if (obs() !== rst_st) begin
      n_fail++; $display("FAIL reset_mid_stall: got %h, expected %h", obs(), rst_st);
    end
    jumpD = 1; pcjumpD = 32'hFFFF_FFFC; tick(); idle();
    n_checks++;
    if (pcF !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL jump_to_top: got %h, expected fffffffc", pcF);
    end
    tick();
    n_checks++;
    if ({pcF, pcplus4D} !== {32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h p4D=%h, expected pc=0 p4D=0", pcF, pcplus4D);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset     = ($urandom_range(0, 79) == 0);
      stallD    = ($urandom_range(0, 2) == 0);
      stallF    = ($urandom_range(0, 39) == 0) ? !stallD : stallD;
      flushE    = stallD ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      pcsrcD    = ($urandom_range(0, 4) == 0);
      jumpD     = ($urandom_range(0, 7) == 0);
      pcbranchD = $urandom() & 32'hFFFF_FFFC;
      pcjumpD   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      ctrlD     = CTRL_W'($urandom());
      tick();
      n_checks++;
      if (obs() !== m) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random[%0d]: got %h, expected %h", c, obs(), m);
        bad++;
      end
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_st     = '0;
    rst_st.pc  = RESET_PC;
    m          = '0;
    idle();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_stalled_branch();
    test_protocol_and_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
